// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU-side strobe/bus bundle for the memory responder
//
// Purpose: groups the bus value, MAR/MDR load enables, Read/Write strobes and
// the responder's status/data outputs into one interface.
// Signals:
//   BusMuxOut  [DATA_W]  internal bus value (CPU -> responder)
//   MARin                load MAR from BusMuxOut[ADDR_W-1:0]
//   MDRin                load MDR from BusMuxOut
//   Read, Write          transaction strobes, rising edge starts an access
//   MDR_data   [DATA_W]  MDR contents (responder -> bus mux)
//   MAR_addr   [ADDR_W]  MAR contents
//   Busy                 transaction in progress
//   Done                 one-cycle completion pulse
//   ErrFlag              sticky collision flag (Read and Write edges together)
// Modports: master = CPU/datapath side, slave = responder side.
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] MDR_data;
  logic [ADDR_W-1:0] MAR_addr;
  logic              Busy;
  logic              Done;
  logic              ErrFlag;

  modport master (
    output BusMuxOut, MARin, MDRin, Read, Write,
    input  MDR_data, MAR_addr, Busy, Done, ErrFlag
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read, Write,
    output MDR_data, MAR_addr, Busy, Done, ErrFlag
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR holder, word RAM and wait-state sequencer
//
// Purpose: services one RAM transaction per rising edge of Read or Write,
// with optional wait states, and signals completion with a one-cycle Done.
// Build option: define MEM_WAIT_EN to insert WAIT_CYCLES wait states per
// access; without it the WAIT state and counter are absent and every access
// takes one cycle to Done.
// Ports:
//   i_clk  system clock, rising-edge active
//   i_rst  asynchronous active-high reset (RAM contents are kept)
//   bus    mem_responder_if.slave (BusMuxOut, MARin, MDRin, Read, Write in;
//          MDR_data, MAR_addr, Busy, Done, ErrFlag out)
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mem_responder_if.slave  bus
);

`ifdef MEM_WAIT_EN
  localparam int W     = WAIT_CYCLES;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_read_q;
  logic              r_write_q;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [ADDR_W-1:0] r_addr_l;
  logic [DATA_W-1:0] r_wdata_l;
  logic              r_op_rd;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_accept;
  logic              w_set_err;
  logic              w_mem_rd;
  logic              w_mem_wr;

`ifdef MEM_WAIT_EN
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
`endif

  logic [DATA_W-1:0] r_ram [0:(1<<ADDR_W)-1];

  assign w_rd_req = bus.Read  & ~r_read_q;
  assign w_wr_req = bus.Write & ~r_write_q;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_set_err   = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
`ifdef MEM_WAIT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rd_req || w_wr_req) begin
          w_accept  = 1'b1;
          // Colliding strobes: the read is performed, the write is dropped.
          w_set_err = w_rd_req & w_wr_req;
`ifdef MEM_WAIT_EN
          w_cnt_nxt   = CNT_W'(W);
          w_state_nxt = (W > 0) ? S_WAIT : S_ACCESS;
`else
          w_state_nxt = S_ACCESS;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_ACCESS;
        end
      end
`endif
      S_ACCESS: begin
        w_mem_rd    = r_op_rd;
        w_mem_wr    = ~r_op_rd;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_read_q  <= 1'b0;
      r_write_q <= 1'b0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_addr_l  <= '0;
      r_wdata_l <= '0;
      r_op_rd   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_read_q  <= bus.Read;
      r_write_q <= bus.Write;
      r_busy    <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_ACCESS);
      r_done    <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        // Snapshot so later MAR/bus activity cannot disturb the access.
        r_addr_l  <= r_mar;
        r_wdata_l <= bus.BusMuxOut;
        r_op_rd   <= w_rd_req;
      end

      if (w_set_err) begin
        r_err <= 1'b1;
      end

      if (bus.MARin) begin
        r_mar <= bus.BusMuxOut[ADDR_W-1:0];
      end

      // Memory load wins over MDRin; MDRin is also blocked during an access
      // and on a read request edge so it cannot race the read data.
      if (w_mem_rd) begin
        r_mdr <= r_ram[r_addr_l];
      end else if (bus.MDRin && !r_busy && !w_rd_req) begin
        r_mdr <= bus.BusMuxOut;
      end
    end
  end

`ifdef MEM_WAIT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  // Write enable is only ever asserted from ACCESS, so a reset that drops
  // the FSM to IDLE also cancels any pending write.
  always_ff @(posedge i_clk) begin
    if (w_mem_wr) begin
      r_ram[r_addr_l] <= r_wdata_l;
    end
  end

  assign bus.MDR_data = r_mdr;
  assign bus.MAR_addr = r_mar;
  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
  assign bus.ErrFlag  = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 9;
  localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_EN
  localparam int W = WAIT_CYCLES;
`else
  localparam int W = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_if ();

  mem_responder #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(u_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, MAR, MDR and error flag.
  logic [31:0] m_mem [0:511];
  bit          m_valid [0:511];
  logic [31:0] m_mdr;
  logic [8:0]  m_mar;
  logic        m_err;

  task automatic model_reset();
    m_mdr = '0;
    m_mar = '0;
    m_err = 1'b0;
  endtask

  task automatic set_mar(input logic [8:0] addr, input logic [22:0] upper);
    @(negedge clk);
    u_if.BusMuxOut = {upper, addr};
    u_if.MARin     = 1'b1;
    @(negedge clk);
    u_if.MARin     = 1'b0;
    m_mar = addr;
  endtask

  // Raise the requested strobes for one cycle and observe the response window.
  task automatic run_op(input logic rd, input logic wr,
                        output int done_k, output int busy_n, output int done_n);
    done_k = 0;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    u_if.Read  = rd;
    u_if.Write = wr;
    for (int k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        u_if.Read  = 1'b0;
        u_if.Write = 1'b0;
      end
      if (u_if.Busy)  busy_n++;
      if (u_if.Done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
    end
  endtask

  task automatic test_reset();
    u_if.BusMuxOut = '0;
    u_if.MARin = 1'b0;
    u_if.MDRin = 1'b0;
    u_if.Read  = 1'b0;
    u_if.Write = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (u_if.MDR_data !== 32'h0 || u_if.MAR_addr !== 9'h0) begin
      errors++;
      $display("FAIL reset_regs mdr=%h mar=%h exp 0/0", u_if.MDR_data, u_if.MAR_addr);
    end
    checks++;
    if (u_if.Busy !== 1'b0 || u_if.Done !== 1'b0 || u_if.ErrFlag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b err=%b exp 0/0/0", u_if.Busy, u_if.Done, u_if.ErrFlag);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    int dk, bn, dn;
    logic [8:0]  addrs [2];
    logic [31:0] datas [2];
    addrs[0] = 9'h005; datas[0] = 32'hDEADBEEF;
    addrs[1] = 9'h1FF; datas[1] = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      set_mar(addrs[i], 23'h0);
      u_if.BusMuxOut = datas[i];
      run_op(1'b0, 1'b1, dk, bn, dn);
      m_mem[m_mar] = datas[i]; m_valid[m_mar] = 1'b1;
      checks++;
      if (dk != W + 2 || dn != 1) begin
        errors++;
        $display("FAIL wr_done_latency k=%0d pulses=%0d exp k=%0d pulses=1", dk, dn, W + 2);
      end
      checks++;
      if (bn != W + 1) begin
        errors++;
        $display("FAIL wr_busy_cycles got=%0d exp=%0d", bn, W + 1);
      end
      u_if.BusMuxOut = '0;
      run_op(1'b1, 1'b0, dk, bn, dn);
      m_mdr = m_mem[m_mar];
      checks++;
      if (u_if.MDR_data !== m_mdr) begin
        errors++;
        $display("FAIL rd_data addr=%h got=%h exp=%h", m_mar, u_if.MDR_data, m_mdr);
      end
      checks++;
      if (dk != W + 2 || bn != W + 1 || dn != 1) begin
        errors++;
        $display("FAIL rd_timing k=%0d busy=%0d pulses=%0d exp %0d/%0d/1", dk, bn, dn, W + 2, W + 1);
      end
    end
  endtask

  task automatic test_mar_mdrin();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      set_mar(v[8:0], v[31:9] | 23'h1);
      checks++;
      if (u_if.MAR_addr !== m_mar) begin
        errors++;
        $display("FAIL mar_load got=%h exp=%h", u_if.MAR_addr, m_mar);
      end
      v = $urandom;
      @(negedge clk);
      u_if.BusMuxOut = v;
      u_if.MDRin = 1'b1;
      @(negedge clk);
      u_if.MDRin = 1'b0;
      m_mdr = v;
      checks++;
      if (u_if.MDR_data !== m_mdr) begin
        errors++;
        $display("FAIL mdrin_load got=%h exp=%h", u_if.MDR_data, m_mdr);
      end
    end
  endtask

  task automatic test_random();
    int dk, bn, dn;
    logic [8:0]  pool [6];
    logic [8:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) pool[i] = 9'($urandom_range(0, 511));
    for (int it = 0; it < 24; it++) begin
      a = pool[$urandom_range(0, 5)];
      set_mar(a, 23'($urandom));
      if (!m_valid[a] || $urandom_range(0, 1) == 0) begin
        d = $urandom;
        u_if.BusMuxOut = d;
        run_op(1'b0, 1'b1, dk, bn, dn);
        m_mem[a] = d; m_valid[a] = 1'b1;
      end else begin
        u_if.BusMuxOut = $urandom;
        run_op(1'b1, 1'b0, dk, bn, dn);
        m_mdr = m_mem[a];
      end
      checks++;
      if (u_if.MDR_data !== m_mdr || dn != 1) begin
        errors++;
        $display("FAIL random_op it=%0d addr=%h mdr=%h exp=%h pulses=%0d", it, a, u_if.MDR_data, m_mdr, dn);
      end
    end
  endtask

  task automatic test_simultaneous();
    int dk, bn, dn;
    set_mar(9'h010, 23'h0);
    u_if.BusMuxOut = 32'hA5A5A5A5;
    run_op(1'b0, 1'b1, dk, bn, dn);
    m_mem[m_mar] = 32'hA5A5A5A5; m_valid[m_mar] = 1'b1;
    u_if.BusMuxOut = 32'h0;
    run_op(1'b1, 1'b1, dk, bn, dn);
    m_mdr = m_mem[m_mar];
    m_err = 1'b1;
    checks++;
    if (u_if.MDR_data !== m_mdr || dn != 1) begin
      errors++;
      $display("FAIL simul_read got=%h exp=%h pulses=%0d", u_if.MDR_data, m_mdr, dn);
    end
    checks++;
    if (u_if.ErrFlag !== m_err) begin
      errors++;
      $display("FAIL simul_errflag got=%b exp=%b", u_if.ErrFlag, m_err);
    end
    u_if.BusMuxOut = 32'h0;
    run_op(1'b1, 1'b0, dk, bn, dn);
    m_mdr = m_mem[m_mar];
    checks++;
    if (u_if.MDR_data !== m_mdr || u_if.ErrFlag !== m_err) begin
      errors++;
      $display("FAIL simul_ram_kept mdr=%h exp=%h err=%b exp=%b", u_if.MDR_data, m_mdr, u_if.ErrFlag, m_err);
    end
  endtask

  task automatic test_held_strobe();
    int dk, bn, dn;
    int pulses;
    set_mar(9'h030, 23'h0);
    u_if.BusMuxOut = 32'h0BADF00D;
    run_op(1'b0, 1'b1, dk, bn, dn);
    m_mem[m_mar] = 32'h0BADF00D; m_valid[m_mar] = 1'b1;
    u_if.BusMuxOut = 32'h00000099;
    pulses = 0;
    @(negedge clk);
    u_if.Read = 1'b1;
    @(negedge clk);
    u_if.Write = 1'b1;
    if (u_if.Done) pulses++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (u_if.Done) pulses++;
    end
    u_if.Read  = 1'b0;
    u_if.Write = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (u_if.Done) pulses++;
    end
    m_mdr = m_mem[m_mar];
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_strobe_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (u_if.MDR_data !== m_mdr) begin
      errors++;
      $display("FAIL held_strobe_data got=%h exp=%h", u_if.MDR_data, m_mdr);
    end
    u_if.BusMuxOut = 32'h0;
    run_op(1'b1, 1'b0, dk, bn, dn);
    checks++;
    if (u_if.MDR_data !== m_mem[m_mar]) begin
      errors++;
      $display("FAIL busy_write_ignored got=%h exp=%h", u_if.MDR_data, m_mem[m_mar]);
    end
  endtask

  task automatic test_abort();
    int dk, bn, dn;
    set_mar(9'h020, 23'h0);
    u_if.BusMuxOut = 32'h11111111;
    run_op(1'b0, 1'b1, dk, bn, dn);
    m_mem[m_mar] = 32'h11111111; m_valid[m_mar] = 1'b1;
    u_if.BusMuxOut = 32'h22222222;
    @(negedge clk);
    u_if.Write = 1'b1;
    @(negedge clk);
    u_if.Write = 1'b0;
    checks++;
    if (u_if.Busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got=%b exp=1", u_if.Busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (u_if.Busy !== 1'b0 || u_if.MAR_addr !== 9'h0 || u_if.MDR_data !== 32'h0 || u_if.ErrFlag !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_reset busy=%b mar=%h mdr=%h err=%b exp all 0",
               u_if.Busy, u_if.MAR_addr, u_if.MDR_data, u_if.ErrFlag);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < W + 3; k++) @(negedge clk);
    set_mar(9'h020, 23'h0);
    u_if.BusMuxOut = 32'h0;
    run_op(1'b1, 1'b0, dk, bn, dn);
    m_mdr = m_mem[m_mar];
    checks++;
    if (u_if.MDR_data !== m_mdr) begin
      errors++;
      $display("FAIL abort_ram_unchanged got=%h exp=%h", u_if.MDR_data, m_mdr);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      m_valid[i] = 1'b0;
      m_mem[i]   = '0;
    end
    model_reset();
    test_reset();
    test_write_read();
    test_mar_mdrin();
    test_random();
    test_simultaneous();
    test_held_strobe();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's Read/Write strobes. Holds MAR and MDR, a word-addressed RAM, and a wait-state sequencer; it services one transaction per rising edge of Read or Write and signals completion with a one-cycle Done pulse. Sits between the internal bus (BusMuxOut) and the datapath's MDR-to-bus path.

## Interface
- DATA_W, 32, word width
- ADDR_W, 9, RAM address width (depth 2^ADDR_W words)
- WAIT_CYCLES, 2, extra wait cycles per access (used only with MEM_WAIT_EN)
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-high reset
- BusMuxOut  input  DATA_W  internal bus value
- MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0]
- MDRin  input  1  load MDR from BusMuxOut (ignored while Busy or on a Read edge)
- Read  input  1  read strobe (rising edge starts transaction)
- Write  input  1  write strobe (rising edge starts transaction)
- MDR_data  output  DATA_W  MDR contents, to bus mux
- MAR_addr  output  ADDR_W  MAR contents
- Busy  output  1  transaction in progress
- Done  output  1  one-cycle completion pulse
- ErrFlag  output  1  sticky: Read and Write edges in the same cycle

## Operation
- Reset: MAR=0, MDR=0, Busy=0, Done=0, ErrFlag=0, Read_q=Write_q=0, state IDLE. RAM contents are not reset.
- Edge detect: rd_req = Read & ~Read_q; wr_req = Write & ~Write_q. Read_q/Write_q are registered every cycle. A strobe held high for many cycles produces exactly one transaction.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: on rd_req or wr_req, latch addr_l=MAR, wdata_l=BusMuxOut, op_l (read has priority). Load cnt=W. Go to WAIT if W>0, else ACCESS. If both requests occur together, perform the read, drop the write, and set ErrFlag (cleared only by Reset).
- WAIT: cnt decrements each edge. Go to ACCESS on the edge where cnt==1.
- ACCESS: on the leaving edge, read sets MDR=RAM[addr_l], write sets RAM[addr_l]=wdata_l. Done<=1, go to DONE.
- DONE: Done=1 for this cycle only. Return to IDLE next edge. Requests arriving in DONE, WAIT or ACCESS are ignored, not queued.
- Busy=1 in WAIT and ACCESS.
- MARin/MDRin act in any state. MAR changes during a transaction do not affect addr_l. MDRin is ignored while Busy, in the ACCESS-leaving edge, and on the rd_req edge; the memory load wins.
- Address is unsigned and modulo 2^ADDR_W; no bounds fault. cnt width is $clog2(WAIT_CYCLES+1), minimum 1.
- Reset mid-transaction: aborts immediately. A pending write is not committed; RAM is unchanged.

## Timing
- Request sampled at edge N. Define W = WAIT_CYCLES with the macro, else 0.
- Busy is high from edge N to edge N+1+W.
- MDR (read) or RAM (write) is updated at edge N+1+W.
- Done is high from edge N+1+W to edge N+2+W.
- The next transaction can be accepted at edge N+2+W or later.
- Read-after-write to the same address returns the new data.
- Outputs are registered. MDR_data and MAR_addr change only on edges or Reset.

## Configuration
- MEM_WAIT_EN defined: W=WAIT_CYCLES; WAIT state and counter are present; latency is WAIT_CYCLES+1 cycles to Done.
- MEM_WAIT_EN undefined: WAIT state and counter are removed; W=0; latency is 1 cycle to Done; the WAIT_CYCLES value is ignored.

## Test plan
- Reset: assert Reset asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- Write then read (MEM_WAIT_EN, W=2): MARin with bus=0x005, then Write edge with bus=0xDEADBEEF -> Done at edge N+3. Then Read edge -> MDR_data=0xDEADBEEF at edge N+3, Busy high for 3 cycles.
- No-wait build: same sequence -> Done 1 cycle after each request. Read address 0x1FF after writing 0x12345678 -> 0x12345678.
- Simultaneous strobes: Read and Write rise together at address 0x010 holding 0xA5A5A5A5, bus=0x0 -> MDR=0xA5A5A5A5, RAM unchanged, ErrFlag=1 sticky until Reset.
- Held strobe: Read high for 10 cycles -> exactly one Done pulse. Write edge during Busy -> ignored, no RAM change.
- Abort: Write edge to 0x020 (old 0x11111111, bus 0x22222222), Reset asserted in WAIT -> a later read of 0x020 returns 0x11111111.
